// File: rtl/ll_insert_ctrl_pkg.sv
// ll_pkg: shared types and helpers for the linked-list insert controller
package ll_pkg;
    localparam int LL_DATA_W = 4;
    localparam int LL_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_BAD_ADDR  = 2'd2,
        ST_LOOP      = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [LL_DATA_W-1:0] data;
        logic [LL_ADDR_W-1:0] next;
    } node_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ll_insert_ctrl_if.sv
// ll_insert_ctrl_if: request, response, config and debug buses of the insert controller
interface ll_insert_ctrl_if
    import ll_pkg::*;
#(
    parameter int DATA_WIDTH = LL_DATA_W,
    parameter int ADDR_WIDTH = LL_ADDR_W,
    parameter int NUM_REQ    = 2
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_start;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_check;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_new_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_new_data;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic [1:0]                    resp_status;
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [ADDR_WIDTH-1:0]         cfg_addr;
    logic [DATA_WIDTH-1:0]         cfg_data;
    logic [ADDR_WIDTH-1:0]         cfg_next;
    logic [ADDR_WIDTH-1:0]         dbg_addr;
    logic [DATA_WIDTH-1:0]         dbg_data;
    logic [ADDR_WIDTH-1:0]         dbg_next;

    modport master (
        output req_valid, req_start, req_check, req_new_addr, req_new_data,
        output resp_ready, cfg_valid, cfg_addr, cfg_data, cfg_next, dbg_addr,
        input  req_ready, resp_valid, resp_id, resp_status, cfg_ready, dbg_data, dbg_next
    );

    modport slave (
        input  req_valid, req_start, req_check, req_new_addr, req_new_data,
        input  resp_ready, cfg_valid, cfg_addr, cfg_data, cfg_next, dbg_addr,
        output req_ready, resp_valid, resp_id, resp_status, cfg_ready, dbg_data, dbg_next
    );
endinterface

// File: rtl/ll_insert_ctrl_arb.sv
// rr_arbiter: round-robin one-hot grant, pointer moves past the winner on accept
module rr_arbiter
    import ll_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    int idx;

    // scan from the lowest priority upwards so the last hit (closest to ptr) wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
        ptr_d = accept ? ((int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1)) : ptr_q;
    end

    // priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ll_insert_ctrl.sv
// ll_insert_ctrl: arbitrated linked-list insert with node walk and splice
module ll_insert_ctrl
    import ll_pkg::*;
#(
    parameter int DATA_WIDTH = LL_DATA_W,
    parameter int ADDR_WIDTH = LL_ADDR_W,
    parameter int NUM_REQ    = 2
) (
    input logic              clk,
    input logic              rst_n,
    ll_insert_ctrl_if.slave  bus
);
    localparam int ID_W  = id_w(NUM_REQ);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                state_q, state_d;
    status_e               status_q, status_d;
    logic [ADDR_WIDTH-1:0] curr_q, curr_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic [ADDR_WIDTH-1:0] check_q, check_d;
    logic [ADDR_WIDTH-1:0] new_addr_q, new_addr_d;
    logic [DATA_WIDTH-1:0] new_data_q, new_data_d;
    logic [ID_W-1:0]       id_q, id_d;
    node_t                 mem_q [DEPTH];
    node_t                 mem_d [DEPTH];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req_valid),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign bus.req_ready   = accept ? grant : '0;
    assign bus.cfg_ready   = (state_q == S_IDLE);
    assign bus.resp_valid  = (state_q == S_RESP);
    assign bus.resp_id     = id_q;
    assign bus.resp_status = status_q;
    assign bus.dbg_data    = mem_q[bus.dbg_addr].data;
    assign bus.dbg_next    = mem_q[bus.dbg_addr].next;

    // next state: config writes and accepts in IDLE, one node per cycle in WALK
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        curr_d     = curr_q;
        step_d     = step_q;
        check_d    = check_q;
        new_addr_d = new_addr_q;
        new_data_d = new_data_q;
        id_d       = id_q;
        mem_d      = mem_q;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    mem_d[bus.cfg_addr] = '{data: bus.cfg_data, next: bus.cfg_next};
                end else if (|grant) begin
                    accept     = 1'b1;
                    id_d       = grant_id;
                    check_d    = bus.req_check[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    new_addr_d = bus.req_new_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    new_data_d = bus.req_new_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                    curr_d     = bus.req_start[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    step_d     = '0;
                    if (new_addr_d == '0 || check_d == '0 || new_addr_d == check_d) begin
                        state_d  = S_RESP;
                        status_d = ST_BAD_ADDR;
                    end else begin
                        state_d = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (curr_q == '0) begin
                    state_d  = S_RESP;
                    status_d = ST_NOT_FOUND;
                end else if (curr_q == check_q) begin
                    mem_d[check_q].next = new_addr_q;
                    mem_d[new_addr_q]   = '{data: new_data_q, next: mem_q[check_q].next};
                    state_d             = S_RESP;
                    status_d            = ST_OK;
                end else if (step_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d  = S_RESP;
                    status_d = ST_LOOP;
                end else begin
                    curr_d = mem_q[curr_q].next;
                    step_d = step_q + ADDR_WIDTH'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, request context and node array; reset clears the whole list
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            curr_q     <= '0;
            step_q     <= '0;
            check_q    <= '0;
            new_addr_q <= '0;
            new_data_q <= '0;
            id_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            curr_q     <= curr_d;
            step_q     <= step_d;
            check_q    <= check_d;
            new_addr_q <= new_addr_d;
            new_data_q <= new_data_d;
            id_q       <= id_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_ll_insert_ctrl.sv
// tb_ll_insert_ctrl: directed and random inserts checked against a list model
module tb_ll_insert_ctrl;
    import ll_pkg::*;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   rr_ptr = 0;
    logic [DW-1:0] m_data [DEPTH];
    logic [AW-1:0] m_next [DEPTH];

    ll_insert_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    ll_insert_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_next[i] = '0;
        end
    endtask

    // walk the model list; latency counts cycles from accept edge to resp_valid
    task automatic model_insert(input logic [AW-1:0] st, ck, na, input logic [DW-1:0] nd,
                                output status_e status, output int lat);
        logic [AW-1:0] cur;
        logic [AW-1:0] old;
        if (na == 0 || ck == 0 || na == ck) begin
            status = ST_BAD_ADDR;
            lat    = 1;
            return;
        end
        cur = st;
        for (int h = 0; h < DEPTH; h++) begin
            if (cur == 0) begin
                status = ST_NOT_FOUND;
                lat    = h + 2;
                return;
            end
            if (cur == ck) begin
                old        = m_next[ck];
                m_next[ck] = na;
                m_data[na] = nd;
                m_next[na] = old;
                status     = ST_OK;
                lat        = h + 2;
                return;
            end
            cur = m_next[cur];
        end
        status = ST_LOOP;
        lat    = DEPTH + 1;
    endtask

    task automatic set_slot(input int r, input logic [AW-1:0] st, ck, na, input logic [DW-1:0] nd);
        bus.req_start[r*AW +: AW]    = st;
        bus.req_check[r*AW +: AW]    = ck;
        bus.req_new_addr[r*AW +: AW] = na;
        bus.req_new_data[r*DW +: DW] = nd;
    endtask

    // sweep the debug port over every node, then realign to a falling edge
    task automatic dump_cmp(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1;
            chk($sformatf("%s data[%0d]", tag, a), 32'(bus.dbg_data), 32'(m_data[a]));
            chk($sformatf("%s next[%0d]", tag, a), 32'(bus.dbg_next), 32'(m_next[a]));
        end
        @(negedge clk);
    endtask

    // config write with a competing request that must not be granted
    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] nx);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_data  = d;
        bus.cfg_next  = nx;
        set_slot(0, 4'd1, 4'd2, 4'd0, 4'd0);
        bus.req_valid = 2'b01;
        #1;
        chk("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
        chk("req_ready_during_cfg", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        bus.req_valid = '0;
        m_data[a] = d;
        m_next[a] = nx;
        @(negedge clk);
    endtask

    task automatic do_req(input int r, input logic [AW-1:0] st, ck, na, input logic [DW-1:0] nd,
                          input bit poke);
        status_e exp_st;
        int      exp_lat;
        int      n;
        model_insert(st, ck, na, nd, exp_st, exp_lat);
        set_slot(r, st, ck, na, nd);
        bus.req_valid    = '0;
        bus.req_valid[r] = 1'b1;
        bus.cfg_addr     = 4'd6;
        bus.cfg_data     = 4'hF;
        bus.cfg_next     = 4'd1;
        #1;
        n = 0;
        while (bus.req_ready !== (2'b01 << r) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_grant", 32'(bus.req_ready), 32'(2'b01 << r));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            bus.cfg_valid = poke && n == 0;
            #1;
            if (poke && n == 0) chk("cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
            n++;
        end while (bus.resp_valid !== 1'b1 && n < 40);
        bus.cfg_valid = 1'b0;
        chk("resp_latency", 32'(n), 32'(exp_lat));
        chk("resp_status", 32'(bus.resp_status), 32'(exp_st));
        chk("resp_id", 32'(bus.resp_id), 32'(r));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        rr_ptr = (r + 1) % NR;
        @(negedge clk);
        dump_cmp("mem");
    endtask

    initial begin
        int exp_id;
        int n;
        bus.req_valid    = '0;
        bus.req_start    = '0;
        bus.req_check    = '0;
        bus.req_new_addr = '0;
        bus.req_new_data = '0;
        bus.resp_ready   = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_addr     = '0;
        bus.cfg_data     = '0;
        bus.cfg_next     = '0;
        bus.dbg_addr     = '0;
        model_clear();

        // reset values
        #2;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_status", 32'(bus.resp_status), 32'd0);
        dump_cmp("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // build 1->3->5->0 and insert 7 after 3
        cfg_write(4'd1, 4'd1, 4'd3);
        cfg_write(4'd3, 4'd3, 4'd5);
        cfg_write(4'd5, 4'd5, 4'd0);
        do_req(0, 4'd1, 4'd3, 4'd7, 4'hA, 1'b0);
        chk("node3_next", 32'(m_next[3]), 32'd7);
        do_req(1, 4'd1, 4'd9, 4'd8, 4'h2, 1'b0);
        do_req(0, 4'd1, 4'd3, 4'd0, 4'h4, 1'b0);
        do_req(1, 4'd1, 4'd3, 4'd3, 4'h4, 1'b0);

        // 2->4->2 cycle never reaches node 6; a cfg write mid-walk is ignored
        cfg_write(4'd2, 4'd1, 4'd4);
        cfg_write(4'd4, 4'd2, 4'd2);
        do_req(0, 4'd2, 4'd6, 4'd9, 4'h3, 1'b1);

        // random traffic
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(AW'($urandom_range(1, 15)), DW'($urandom), AW'($urandom_range(0, 15)));
            do_req(int'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                   AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
        end

        // both requesters stay valid: grants alternate
        set_slot(0, 4'd1, 4'd2, 4'd0, 4'd1);
        set_slot(1, 4'd3, 4'd4, 4'd0, 4'd2);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 2'b11;
        exp_id = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (bus.req_ready == '0 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("alt_grant", 32'(bus.req_ready), 32'(2'b01 << exp_id));
            @(negedge clk);
            #1;
            chk("alt_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("alt_resp_id", 32'(bus.resp_id), 32'(exp_id));
            chk("alt_resp_status", 32'(bus.resp_status), 32'(ST_BAD_ADDR));
            @(negedge clk);
            exp_id = 1 - exp_id;
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        rr_ptr = exp_id;
        @(negedge clk);

        // response held while resp_ready is low, no new accept
        bus.req_valid = 2'b11;
        exp_id = rr_ptr;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("hold_grant", 32'(bus.req_ready), 32'(2'b01 << exp_id));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_resp_id", 32'(bus.resp_id), 32'(exp_id));
            chk("hold_resp_status", 32'(bus.resp_status), 32'(ST_BAD_ADDR));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = '0;
        rr_ptr = 1 - exp_id;
        @(negedge clk);
        dump_cmp("after_hold");

        // reset in the middle of a walk
        cfg_write(4'd2, 4'd1, 4'd4);
        cfg_write(4'd4, 4'd2, 4'd2);
        set_slot(1, 4'd2, 4'd6, 4'd9, 4'd3);
        bus.req_valid = 2'b10;
        #1;
        n = 0;
        while (bus.req_ready !== 2'b10 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_walk_grant", 32'(bus.req_ready), 32'b10);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("pre_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        model_clear();
        rr_ptr = 0;
        dump_cmp("async_rst");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        set_slot(0, 4'd1, 4'd2, 4'd0, 4'd1);
        set_slot(1, 4'd1, 4'd2, 4'd0, 4'd1);
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_rr_favours_0", 32'(bus.req_ready), 32'b01);
        bus.req_valid = '0;
        @(negedge clk);
        do_req(1, 4'd0, 4'd3, 4'd5, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
